// File: rtl/conv2_pool_relu.sv
// conv2 pooling receiver: 2x2/stride-2 signed max pool over a raster stream.
// Define CONV2_POOL_RELU_EN to clamp negative pooled results to zero.
module conv2_pool_relu #(
    parameter int WIDTH = 14,
    parameter int IN_W  = 8,
    parameter int IN_H  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] data_in,
    output logic signed [WIDTH-1:0] data_out,
    output logic                    valid_out,
    output logic                    frame_done
);

    localparam int COL_W = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int LB_N  = IN_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic signed [WIDTH-1:0] hold_q, hold_d;
    logic signed [WIDTH-1:0] data_out_q, data_out_d;
    logic                    valid_out_q, valid_out_d;
    logic                    frame_done_q, frame_done_d;

    // Holds the horizontal max of each column pair from the even row.
    logic signed [WIDTH-1:0] linebuf_q [LB_N];

    logic [LB_AW-1:0]        lb_addr;
    logic                    lb_we;
    logic signed [WIDTH-1:0] lb_rdata;
    logic signed [WIDTH-1:0] hmax;
    logic signed [WIDTH-1:0] pmax;

    assign lb_addr  = LB_AW'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_addr];
    assign hmax     = (data_in > hold_q) ? data_in : hold_q;
    assign pmax     = (hmax > lb_rdata) ? hmax : lb_rdata;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (valid_in) begin
            if (!col_q[0]) begin
                hold_d = data_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
`ifdef CONV2_POOL_RELU_EN
                data_out_d = pmax[WIDTH-1] ? '0 : pmax;
`else
                data_out_d = pmax;
`endif
                valid_out_d  = 1'b1;
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Datapath storage is never read before being written within a frame.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (lb_we) begin
            linebuf_q[lb_addr] <= hmax;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv2_pool_relu.sv
// Self-checking bench for conv2_pool_relu: frame-level pixel model plus literal pins.
// Honours CONV2_POOL_RELU_EN the same way as the design.
module tb_conv2_pool_relu;

    localparam int WIDTH = 14;
    localparam int IN_W  = 8;
    localparam int IN_H  = 8;
    localparam int NPIX  = IN_W * IN_H;

    logic                    clk;
    logic                    rst_n;
    logic                    valid_in;
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] data_out;
    logic                    valid_out;
    logic                    frame_done;

    conv2_pool_relu #(.WIDTH(WIDTH), .IN_W(IN_W), .IN_H(IN_H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pixels placed in a frame array by arrival index.
    int signed pix [IN_H][IN_W];
    int        idx;
    logic      e_v, e_fd;
    int signed e_d;

    function automatic int signed max2(input int signed a, input int signed b);
        return (a > b) ? a : b;
    endfunction

    initial begin
        idx = 0; e_v = 1'b0; e_fd = 1'b0; e_d = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                idx = 0; e_v = 1'b0; e_fd = 1'b0; e_d = 0;
            end else if (valid_in) begin
                int r, c;
                int signed m;
                r = idx / IN_W;
                c = idx % IN_W;
                pix[r][c] = int'($signed(data_in));
                e_v  = 1'b0;
                e_fd = 1'b0;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = max2(max2(pix[r-1][c-1], pix[r-1][c]), max2(pix[r][c-1], pix[r][c]));
`ifdef CONV2_POOL_RELU_EN
                    if (m < 0) m = 0;
`endif
                    e_d  = m;
                    e_v  = 1'b1;
                    e_fd = (idx == NPIX - 1);
                end
                idx = (idx + 1) % NPIX;
            end else begin
                e_v  = 1'b0;
                e_fd = 1'b0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    logic                    chk_en = 1'b0;
    logic                    gapped = 1'b0;
    logic                    prev_v = 1'b0;
    logic signed [WIDTH-1:0] outs [$];
    int                      done_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid_out", valid_out, e_v);
                check("frame_done", frame_done, e_fd);
                check("data_out", $signed(data_out), e_d);
                if (gapped) check("no_b2b_valid", valid_out && prev_v, 0);
                if (valid_out) outs.push_back(data_out);
                if (frame_done) done_cnt++;
            end
            prev_v = valid_out;
        end
    end

    task automatic send(input int v);
        valid_in = 1'b1;
        data_in  = WIDTH'(v);
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic ramp(input int offs, input int gap);
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++) begin
                send(r * 8 + c + offs);
                if (gap > 0) idle(gap);
            end
    endtask

    initial begin
        rst_n = 1'b0; valid_in = 1'b1; data_in = 14'sd77;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_data_out", $signed(data_out), 0);
        rst_n = 1'b1; valid_in = 1'b0;

        // Back-to-back ramp frame.
        outs.delete(); done_cnt = 0;
        ramp(0, 0); idle(2);
        check("ramp_count", outs.size(), 16);
        if (outs.size() == 16) begin
            check("ramp_out0", outs[0], 9);
            check("ramp_out1", outs[1], 11);
            check("ramp_out4", outs[4], 25);
            check("ramp_out15", outs[15], 63);
        end
        check("ramp_done_cnt", done_cnt, 1);

        // Alternate-cycle stream.
        outs.delete(); gapped = 1'b1;
        ramp(0, 1); idle(2);
        gapped = 1'b0;
        check("gap_count", outs.size(), 16);
        if (outs.size() == 16) begin
            check("gap_out0", outs[0], 9);
            check("gap_out15", outs[15], 63);
        end

        // Constant negative frame.
        outs.delete();
        for (int i = 0; i < NPIX; i++) send(-5);
        idle(2);
        check("neg_count", outs.size(), 16);
        if (outs.size() > 0) begin
`ifdef CONV2_POOL_RELU_EN
            check("neg_out0", outs[0], 0);
`else
            check("neg_out0", {18'd0, outs[0]}, 32'h3FFB);
`endif
        end

        // Extreme window in the top-left, random elsewhere.
        outs.delete();
        for (int i = 0; i < NPIX; i++) begin
            if (i == 0) send(-8192);
            else if (i == 1) send(8191);
            else if (i == IN_W) send(-1);
            else if (i == IN_W + 1) send(0);
            else send(int'($urandom_range(0, 16383)));
        end
        idle(2);
        if (outs.size() > 0) check("extreme_out0", outs[0], 8191);

        // Random values with random gaps.
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < NPIX; i++) begin
                send(int'($urandom_range(0, 16383)));
                idle(int'($urandom_range(0, 2)));
            end
        idle(2);

        // Mid-frame reset, with valid_in high during reset.
        for (int i = 0; i < 20; i++) send(1000 + i);
        rst_n = 1'b0; valid_in = 1'b1; data_in = 14'sd500;
        @(posedge clk); #1;
        rst_n = 1'b1; valid_in = 1'b0;
        outs.delete(); done_cnt = 0;
        for (int i = 0; i < 9; i++) send((i / IN_W) * 8 + i % IN_W);
        check("rst_mid_none_yet", outs.size(), 0);
        for (int i = 9; i < NPIX; i++) send((i / IN_W) * 8 + i % IN_W);
        idle(2);
        check("rst_mid_count", outs.size(), 16);
        if (outs.size() == 16) begin
            check("rst_mid_out0", outs[0], 9);
            check("rst_mid_out15", outs[15], 63);
        end
        check("rst_mid_done", done_cnt, 1);

        // Two frames with no gap between them.
        outs.delete(); done_cnt = 0;
        ramp(0, 0); ramp(100, 0); idle(2);
        check("two_count", outs.size(), 32);
        if (outs.size() == 32) begin
            check("two_out16", outs[16], 109);
            check("two_out31", outs[31], 163);
        end
        check("two_done_cnt", done_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2_pool_relu.md
# conv2_pool_relu

Pooling receiver for the conv2 stage: consumes the 14-bit signed stream produced by one conv2 channel calculator (one value per `valid_in` cycle, raster order, IN_W×IN_H frame) and emits the 2×2/stride-2 max-pooled result. It applies an optional ReLU and drives one value per pooled window to the downstream feature-map buffer / fully-connected stage. One instance sits behind each conv2 channel.

## Interface
- `WIDTH`, 14, sample width (signed two's complement) in and out
- `IN_W`, 8, conv2 output columns per row; even, ≥2
- `IN_H`, 8, conv2 output rows per frame; even, ≥2
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `valid_in`  in  1  qualifies `data_in` for exactly this cycle; may be high on consecutive cycles or with gaps (e.g. alternate-cycle toggling)
- `data_in`  in  WIDTH  signed conv2 sample
- `data_out`  out  WIDTH  pooled (and optionally rectified) sample, registered
- `valid_out`  out  1  one-cycle strobe: `data_out` valid
- `frame_done`  out  1  one-cycle strobe coincident with the last `valid_out` of a frame

## Operation
- Counters `col` (0..IN_W-1) and `row` (0..IN_H-1) advance only on `valid_in`; `col` wraps to 0 and increments `row`; at (IN_H-1, IN_W-1) both wrap to 0 (next frame starts immediately, no idle cycle required).
- Even `col`: sample stored in `hold` register.
- Odd `col`: `hmax = max(hold, data_in)`, signed compare.
  - Even `row`: `hmax` written to line buffer entry `col>>1` (IN_W/2 entries × WIDTH).
  - Odd `row`: `pmax = max(linebuf[col>>1], hmax)`; `pmax` (after ReLU, see Configuration) registered to `data_out`, `valid_out` asserted.
- No arithmetic widening; max is exact, outputs never saturate.
- Outputs per frame: (IN_W/2)×(IN_H/2) = 16 at defaults, raster order.
- `frame_done` asserted with the output for `row`=IN_H-1, `col`=IN_W-1.
- Cycles without `valid_in`: no state change except that `valid_out`/`frame_done` drop to 0.
- Line buffer and `hold` are not reset; their contents are always written before being read within a frame.

## Timing
- Reset: `data_out`=0, `valid_out`=0, `frame_done`=0, `col`=0, `row`=0.
- Latency: `valid_out` rises exactly 1 cycle after the accepting edge of the odd-row/odd-col input sample; `data_out` holds its value until the next output.
- Throughput: 1 input per cycle sustained; no backpressure, no ready signal.
- Reset mid-frame: partial frame discarded, no output emitted for it; the first `valid_in` after release is pixel (0,0).
- `rst_n` low in the same cycle as `valid_in`: reset wins, sample dropped.

## Configuration
- `CONV2_POOL_RELU_EN` defined: `data_out = (pmax < 0) ? 0 : pmax`.
- Undefined: `data_out = pmax`, negatives passed through unchanged (the ReLU is applied elsewhere).

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `valid_in`=1 → `valid_out`=0, `frame_done`=0, `data_out`=0, no output after release until 9 new samples have been accepted.
- Ramp frame, back-to-back valid: `data_in`=row*8+col → 16 outputs, value (2r+1)*8+2c+1 (9, 11, 13, 15, 25, …, 63); each 1 cycle after the sample; `frame_done` only with 63.
- Gapped stream: same ramp with `valid_in` high on alternate cycles → identical output values and order; `valid_out` never high on two consecutive cycles.
- Negatives: all samples -5 → `data_out`=0 with `CONV2_POOL_RELU_EN`; 14'h3FFB without it. Window {-8192, 8191, -1, 0} → 8191.
- Reset mid-frame: assert `rst_n`=0 after 20 samples, then feed a full ramp frame → exactly 16 correct outputs, with the first output following the 10th post-reset sample.
- Two consecutive frames without gaps (second = ramp + 100) → 32 outputs; second frame's first output 109; `frame_done` pulses twice.
